// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for uart_tx_fifo: character push plus queue status.
`timescale 1ns / 1ps

interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                               data_valid;
  logic [DATA_BITS-1:0]               data;
  logic                               data_ready;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;

  // Producer side
  modport master (
    output data_valid,
    output data,
    input  data_ready,
    input  fifo_count
  );

  // Transmitter side
  modport slave (
    input  data_valid,
    input  data,
    output data_ready,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO and a CTS-gated framing FSM.
// Frames are START, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
`timescale 1ns / 1ps

module uart_tx_fifo #(
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus,
  input  logic          cts,
  output logic          tx_busy,
  output logic          tx
);

  localparam int unsigned CLK_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W       = ($clog2(CLK_PER_BIT) > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned IDX_W       = $clog2(DATA_BITS);
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]   BitLast   = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IdxLast   = IDX_W'(DATA_BITS - 1);
  localparam logic               StopLast  = 1'(STOP_BITS - 1);
  localparam logic [COUNT_W-1:0] CountFull = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // CTS synchroniser
  // ---------------------------------------------------------------------------
  logic cts_meta_q;
  logic cts_s;

  // Two-flop synchroniser; only cts_s is used past this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_q <= 1'b0;
      cts_s      <= 1'b0;
    end else begin
      cts_meta_q <= cts;
      cts_s      <= cts_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign full           = (count_q == CountFull);
  assign empty          = (count_q == '0);
  assign push           = bus.data_valid & ~full;
  assign head           = mem_q[rd_ptr_q];
  // A same-cycle pop never frees a slot for the push.
  assign bus.data_ready = ~full;
  assign bus.fifo_count = count_q;

  // Storage array has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;
  logic                 start_ok;
  logic                 load;

  assign bit_done = (bit_cnt_q == BitLast);
  assign start_ok = ~empty & cts_s;

  // Next-state, pop and registered line level; tx_d is derived from the next state so the
  // start bit appears on the same edge as the pop.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    load       = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;
    busy_d     = 1'b0;

    if (state_q != StIdle) begin
      bit_cnt_d = bit_done ? '0 : bit_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          load = 1'b1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          if (idx_q == IdxLast) begin
            stop_cnt_d = 1'b0;
            state_d    = (PARITY != 0) ? StParity : StStop;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (stop_cnt_q == StopLast) begin
            // Chain straight into the next frame when possible: no idle gap.
            if (start_ok) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      pop       = 1'b1;
      state_d   = StStart;
      bit_cnt_d = '0;
      shift_d   = head;
      par_d     = (PARITY == 2) ? ~(^head) : ^head;
    end

    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  // FSM, datapath and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three instances (8N1, 7E2, 8O1) at CLK_PER_BIT = 4,
// checked cycle by cycle against a frame-level line model.
`timescale 1ns / 1ps

module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic cts   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus0 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus2 ();

  logic tx0, tx1, tx2;
  logic busy0, busy1, busy2;

  uart_tx_fifo #(
    .BAUD(10), .CLK_FREQ(40), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_8n1 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .cts(cts), .tx_busy(busy0), .tx(tx0)
  );

  uart_tx_fifo #(
    .BAUD(10), .CLK_FREQ(40), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_7e2 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .cts(cts), .tx_busy(busy1), .tx(tx1)
  );

  uart_tx_fifo #(
    .BAUD(10), .CLK_FREQ(40), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_8o1 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .cts(cts), .tx_busy(busy2), .tx(tx2)
  );

  // Observation mux: sel picks which instance the current scenario watches.
  int   sel = 0;
  logic tx_mon;
  logic busy_mon;
  int   cnt_mon;

  always_comb begin
    tx_mon   = tx0;
    busy_mon = busy0;
    cnt_mon  = int'(bus0.fifo_count);
    case (sel)
      1: begin
        tx_mon   = tx1;
        busy_mon = busy1;
        cnt_mon  = int'(bus1.fifo_count);
      end
      2: begin
        tx_mon   = tx2;
        busy_mon = busy2;
        cnt_mon  = int'(bus2.fifo_count);
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Expected line, one entry per bit period, for everything still to be transmitted.
  bit exp_q[$];

  // Reference model: frame = start 0, data LSB first, parity from the count of ones, stops.
  function automatic void model_frame(input int unsigned ch, input int dbits, input int par,
                                      input int stops);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dbits; i++) begin
      bit b = bit'((ch >> i) & 1);
      ones += int'(b);
      exp_q.push_back(b);
    end
    if (par == 1) exp_q.push_back(bit'(ones % 2));
    if (par == 2) exp_q.push_back(bit'(1 - (ones % 2)));
    for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
  endfunction

  task automatic drive_valid(input int s, input logic v, input int unsigned ch);
    case (s)
      1: begin
        bus1.data_valid = v;
        bus1.data       = 7'(ch);
      end
      2: begin
        bus2.data_valid = v;
        bus2.data       = 8'(ch);
      end
      default: begin
        bus0.data_valid = v;
        bus0.data       = 8'(ch);
      end
    endcase
  endtask

  // Single-cycle push; returns at the negedge after the push edge.
  task automatic push_one(input int s, input int unsigned ch);
    @(negedge clk);
    drive_valid(s, 1'b1, ch);
    @(negedge clk);
    drive_valid(s, 1'b0, 0);
  endtask

  // Entered at the negedge where the start bit is first visible; checks every cycle of the
  // expected line and returns at the negedge after the last stop-bit cycle.
  task automatic expect_line(input string name);
    int total = exp_q.size() * CPB;
    for (int c = 0; c < total; c++) begin
      n_checks++;
      if (tx_mon !== exp_q[c / CPB] || busy_mon !== 1'b1) begin
        $display("FAIL %s cycle %0d: tx=%b busy=%b, required tx=%b busy=1",
                 name, c, tx_mon, busy_mon, exp_q[c / CPB]);
      end else begin
        n_pass++;
      end
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic check_idle(input string name, input int exp_cnt);
    n_checks++;
    if (tx_mon !== 1'b1 || busy_mon !== 1'b0 || cnt_mon !== exp_cnt) begin
      $display("FAIL %s idle: tx=%b busy=%b count=%0d, required tx=1 busy=0 count=%0d",
               name, tx_mon, busy_mon, cnt_mon, exp_cnt);
    end else begin
      n_pass++;
    end
  endtask

  // Queue one character on an idle instance with cts_s high and check push-to-start latency.
  task automatic run_frame(input int s, input int unsigned ch, input int dbits, input int par,
                           input int stops, input string name);
    sel = s;
    cts = 1'b1;
    repeat (3) @(negedge clk);
    model_frame(ch, dbits, par, stops);
    push_one(s, ch);
    n_checks++;
    if (tx_mon !== 1'b1 || cnt_mon !== 1) begin
      $display("FAIL %s after push: tx=%b count=%0d, required tx=1 count=1",
               name, tx_mon, cnt_mon);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (tx_mon !== 1'b0 || busy_mon !== 1'b1 || cnt_mon !== 0) begin
      $display("FAIL %s start: tx=%b busy=%b count=%0d, required tx=0 busy=1 count=0",
               name, tx_mon, busy_mon, cnt_mon);
    end else begin
      n_pass++;
    end
    expect_line(name);
    check_idle(name, 0);
  endtask

  // Raise cts with data queued: start bit must appear exactly on the third edge.
  task automatic cts_to_start(input string name, input int exp_cnt_after);
    @(negedge clk);
    cts = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (tx_mon !== 1'b1 || busy_mon !== 1'b0) begin
        $display("FAIL %s early start: tx=%b busy=%b, required tx=1 busy=0",
                 name, tx_mon, busy_mon);
      end else begin
        n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx_mon !== 1'b0 || busy_mon !== 1'b1 || cnt_mon !== exp_cnt_after) begin
      $display("FAIL %s start: tx=%b busy=%b count=%0d, required tx=0 busy=1 count=%0d",
               name, tx_mon, busy_mon, cnt_mon, exp_cnt_after);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || bus0.fifo_count !== 3'd0 || bus0.data_ready !== 1'b1)
    begin
      $display("FAIL reset: tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
               tx0, busy0, bus0.fifo_count, bus0.data_ready);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (tx1 !== 1'b1 || tx2 !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      $display("FAIL reset others: tx=%b%b busy=%b%b, required tx=11 busy=00",
               tx1, tx2, busy1, busy2);
    end else begin
      n_pass++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 0;
    check_idle("after reset", 0);
  endtask

  task automatic test_8n1();
    run_frame(0, 32'hA5, 8, 0, 1, "8n1 0xA5");
  endtask

  task automatic test_7e2();
    run_frame(1, 32'h55, 7, 1, 2, "7e2 0x55");
  endtask

  task automatic test_odd_parity();
    run_frame(2, 32'h00, 8, 2, 1, "8o1 0x00");
  endtask

  task automatic test_fifo_fill();
    sel = 0;
    cts = 1'b0;
    repeat (3) @(negedge clk);
    drive_valid(0, 1'b1, 1);
    for (int i = 1; i <= 5; i++) begin
      drive_valid(0, 1'b1, i);
      @(negedge clk);
      n_checks++;
      if (cnt_mon !== ((i < 4) ? i : 4) || bus0.data_ready !== (i < 4)) begin
        $display("FAIL fill push %0d: count=%0d ready=%b, required count=%0d ready=%b",
                 i, cnt_mon, bus0.data_ready, (i < 4) ? i : 4, (i < 4));
      end else begin
        n_pass++;
      end
    end
    drive_valid(0, 1'b0, 0);
    for (int i = 1; i <= 4; i++) model_frame(i, 8, 0, 1);
    cts_to_start("fill b2b", 3);
    expect_line("fill b2b");
    check_idle("fill b2b", 0);
  endtask

  task automatic test_cts_drop();
    int unsigned b1 = $urandom_range(0, 255);
    int unsigned b2 = $urandom_range(0, 255);
    sel = 0;
    cts = 1'b1;
    repeat (3) @(negedge clk);
    drive_valid(0, 1'b1, b1);
    @(negedge clk);
    drive_valid(0, 1'b1, b2);
    @(negedge clk);
    drive_valid(0, 1'b0, 0);
    n_checks++;
    if (tx_mon !== 1'b0 || cnt_mon !== 1) begin
      $display("FAIL cts drop start: tx=%b count=%0d, required tx=0 count=1", tx_mon, cnt_mon);
    end else begin
      n_pass++;
    end
    model_frame(b1, 8, 0, 1);
    fork
      expect_line("cts drop frame1");
      begin
        repeat (12) @(negedge clk);
        cts = 1'b0;
      end
    join
    check_idle("cts drop end", 1);
    repeat (6) @(negedge clk);
    check_idle("cts drop hold", 1);
    model_frame(b2, 8, 0, 1);
    cts_to_start("cts raise", 0);
    expect_line("cts drop frame2");
    check_idle("cts drop final", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(1, 4);
      sel = 0;
      cts = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < n; k++) begin
        int unsigned ch = $urandom_range(0, 255);
        model_frame(ch, 8, 0, 1);
        drive_valid(0, 1'b1, ch);
        @(negedge clk);
      end
      drive_valid(0, 1'b0, 0);
      n_checks++;
      if (cnt_mon !== n || bus0.data_ready !== (n < 4)) begin
        $display("FAIL random queue %0d: count=%0d ready=%b, required count=%0d ready=%b",
                 it, cnt_mon, bus0.data_ready, n, (n < 4));
      end else begin
        n_pass++;
      end
      cts_to_start("random", n - 1);
      expect_line("random line");
      check_idle("random end", 0);
    end
    for (int it = 0; it < 2; it++) begin
      run_frame(1, $urandom_range(0, 127), 7, 1, 2, "random 7e2");
      run_frame(2, $urandom_range(0, 255), 8, 2, 1, "random 8o1");
    end
  endtask

  task automatic test_reset_mid_frame();
    bit saw_low = 1'b0;
    sel = 0;
    cts = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive_valid(0, 1'b1, 8'h3C + k);
      @(negedge clk);
    end
    drive_valid(0, 1'b0, 0);
    cts_to_start("reset mid", 3);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || bus0.fifo_count !== 3'd0 || bus0.data_ready !== 1'b1)
    begin
      $display("FAIL reset mid frame: tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
               tx0, busy0, bus0.fifo_count, bus0.data_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_mon !== 1'b1 || busy_mon !== 1'b0) saw_low = 1'b1;
    end
    n_checks++;
    if (saw_low !== 1'b0) begin
      $display("FAIL reset discard: frame activity seen=%b, required 0", saw_low);
    end else begin
      n_pass++;
    end
    check_idle("reset discard", 0);
  endtask

  initial begin
    bus0.data_valid = 1'b0;
    bus0.data       = '0;
    bus1.data_valid = 1'b0;
    bus1.data       = '0;
    bus2.data_valid = 1'b0;
    bus2.data       = '0;
    test_reset();
    test_8n1();
    test_7e2();
    test_odd_parity();
    test_fifo_fill();
    test_cts_drop();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
